// File: rtl/hazard_scoreboard.sv
// Stall / forwarding scoreboard for a 5-stage MIPS pipeline: shadows E/M/W
// destination and Tnew, derives stall and forward selects, tracks HI/LO busy.
module hazard_scoreboard #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned TNEW_W  = 2,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10,
    parameter int unsigned CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs_addr,
    input  logic [REG_AW-1:0] d_rt_addr,
    input  logic [TNEW_W-1:0] d_rs_tuse,
    input  logic [TNEW_W-1:0] d_rt_tuse,
    input  logic [REG_AW-1:0] d_wr_addr,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_md_start,
    input  logic              d_md_div,
    input  logic              d_md_use,
    output logic              stall,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic              fwd_rt_m,
    output logic              md_busy
);

    logic              e_valid_q, e_valid_d;
    logic [REG_AW-1:0] e_wr_q,    e_wr_d;
    logic [TNEW_W-1:0] e_tnew_q,  e_tnew_d;
    logic [REG_AW-1:0] e_rs_q,    e_rs_d;
    logic [REG_AW-1:0] e_rt_q,    e_rt_d;

    logic              m_valid_q, m_valid_d;
    logic [REG_AW-1:0] m_wr_q,    m_wr_d;
    logic [TNEW_W-1:0] m_tnew_q,  m_tnew_d;
    logic [REG_AW-1:0] m_rt_q,    m_rt_d;

    logic              w_valid_q, w_valid_d;
    logic [REG_AW-1:0] w_wr_q,    w_wr_d;

    logic [CNT_W-1:0]  md_cnt_q,  md_cnt_d;

    logic              issue;
    logic              haz_rs;
    logic              haz_rt;

    function automatic logic hit(input logic              v,
                                 input logic [REG_AW-1:0] wr,
                                 input logic [REG_AW-1:0] a);
        return v && (a != '0) && (a == wr);
    endfunction

    function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    // Youngest producer wins; a younger match still computing blocks older copies.
    function automatic logic [1:0] fwd_d_sel(input logic [REG_AW-1:0] a);
        logic [1:0] sel;
        sel = 2'd0;
        if (hit(e_valid_q, e_wr_q, a))
            sel = (e_tnew_q == '0) ? 2'd1 : 2'd0;
        else if (hit(m_valid_q, m_wr_q, a))
            sel = (m_tnew_q == '0) ? 2'd2 : 2'd0;
        else if (hit(w_valid_q, w_wr_q, a))
            sel = 2'd3;
        return sel;
    endfunction

    function automatic logic [1:0] fwd_e_sel(input logic [REG_AW-1:0] a);
        logic [1:0] sel;
        sel = 2'd0;
        if (hit(m_valid_q, m_wr_q, a) && (m_tnew_q == '0))
            sel = 2'd2;
        else if (hit(w_valid_q, w_wr_q, a))
            sel = 2'd3;
        return sel;
    endfunction

    always_comb begin
        haz_rs = 1'b0;
        haz_rt = 1'b0;
        if (d_rs_tuse != '1)
            haz_rs = (hit(e_valid_q, e_wr_q, d_rs_addr) && (e_tnew_q > d_rs_tuse)) ||
                     (hit(m_valid_q, m_wr_q, d_rs_addr) && (m_tnew_q > d_rs_tuse));
        if (d_rt_tuse != '1)
            haz_rt = (hit(e_valid_q, e_wr_q, d_rt_addr) && (e_tnew_q > d_rt_tuse)) ||
                     (hit(m_valid_q, m_wr_q, d_rt_addr) && (m_tnew_q > d_rt_tuse));
        md_busy  = (md_cnt_q != '0);
        stall    = d_valid && (haz_rs || haz_rt || (d_md_use && md_busy));
        fwd_rs_d = fwd_d_sel(d_rs_addr);
        fwd_rt_d = fwd_d_sel(d_rt_addr);
        fwd_rs_e = fwd_e_sel(e_rs_q);
        fwd_rt_e = fwd_e_sel(e_rt_q);
        fwd_rt_m = hit(w_valid_q, w_wr_q, m_rt_q);
    end

    // Bubbles and flushed entries clear every field so stale addresses cannot match.
    always_comb begin
        issue     = d_valid && !stall && !flush;

        e_valid_d = issue;
        e_wr_d    = issue ? d_wr_addr : '0;
        e_tnew_d  = issue ? d_tnew    : '0;
        e_rs_d    = issue ? d_rs_addr : '0;
        e_rt_d    = issue ? d_rt_addr : '0;

        m_valid_d = e_valid_q && !flush;
        m_wr_d    = flush ? '0 : e_wr_q;
        m_tnew_d  = flush ? '0 : tnew_dec(e_tnew_q);
        m_rt_d    = flush ? '0 : e_rt_q;

        w_valid_d = m_valid_q && !flush;
        w_wr_d    = flush ? '0 : m_wr_q;

        md_cnt_d  = md_cnt_q;
        if (issue && d_md_start)
            md_cnt_d = d_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_valid_q <= 1'b0;
            e_wr_q    <= '0;
            e_tnew_q  <= '0;
            e_rs_q    <= '0;
            e_rt_q    <= '0;
            m_valid_q <= 1'b0;
            m_wr_q    <= '0;
            m_tnew_q  <= '0;
            m_rt_q    <= '0;
            w_valid_q <= 1'b0;
            w_wr_q    <= '0;
            md_cnt_q  <= '0;
        end else begin
            e_valid_q <= e_valid_d;
            e_wr_q    <= e_wr_d;
            e_tnew_q  <= e_tnew_d;
            e_rs_q    <= e_rs_d;
            e_rt_q    <= e_rt_d;
            m_valid_q <= m_valid_d;
            m_wr_q    <= m_wr_d;
            m_tnew_q  <= m_tnew_d;
            m_rt_q    <= m_rt_d;
            w_valid_q <= w_valid_d;
            w_wr_q    <= w_wr_d;
            md_cnt_q  <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed + random bench for hazard_scoreboard against an in-flight
// instruction list model (absolute issue cycles, no stage registers).
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset, flush, d_valid;
    logic [4:0] d_rs_addr, d_rt_addr, d_wr_addr;
    logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic       d_md_start, d_md_div, d_md_use;
    logic       stall, fwd_rt_m, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_AW(5), .TNEW_W(2), .MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .d_valid(d_valid),
        .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .d_wr_addr(d_wr_addr), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
        .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
    );

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned n_fail = 0;

    // Each issued instruction remembers the cycle it entered E; its stage and
    // remaining latency follow from the current cycle number.
    typedef struct {
        int wr;
        int rs;
        int rt;
        int tnew;
        int enter;
    } ent_t;
    ent_t q[$];
    int   cyc = 0;
    bit   md_have = 0;
    int   md_iss = 0;
    int   md_lat = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int find_stage(input int s);
        for (int i = 0; i < q.size(); i++)
            if (cyc - q[i].enter == s) return i;
        return -1;
    endfunction

    // -1: no producer of a at stage s; otherwise cycles until its result exists.
    function automatic int hit_rem(input int s, input int a);
        int i, r;
        i = find_stage(s);
        if (i < 0 || a == 0 || q[i].wr != a) return -1;
        r = q[i].tnew - s;
        return (r > 0) ? r : 0;
    endfunction

    function automatic bit exp_busy();
        return md_have && (cyc - md_iss) <= md_lat;
    endfunction

    function automatic bit exp_stall();
        bit h = 0;
        for (int s = 0; s < 2; s++) begin
            if (d_rs_tuse != 2'd3 && hit_rem(s, int'(d_rs_addr)) > int'(d_rs_tuse)) h = 1;
            if (d_rt_tuse != 2'd3 && hit_rem(s, int'(d_rt_addr)) > int'(d_rt_tuse)) h = 1;
        end
        if (d_md_use && exp_busy()) h = 1;
        return d_valid && h;
    endfunction

    function automatic int exp_fwd_d(input int a);
        int r;
        for (int s = 0; s < 3; s++) begin
            r = hit_rem(s, a);
            if (r >= 0) return (r == 0) ? s + 1 : 0;
        end
        return 0;
    endfunction

    function automatic int exp_fwd_e(input bit use_rt);
        int i, a;
        i = find_stage(0);
        if (i < 0) return 0;
        a = use_rt ? q[i].rt : q[i].rs;
        if (hit_rem(1, a) == 0) return 2;
        if (hit_rem(2, a) >= 0) return 3;
        return 0;
    endfunction

    function automatic int exp_fwd_m();
        int i;
        i = find_stage(1);
        if (i < 0) return 0;
        return (hit_rem(2, q[i].rt) >= 0) ? 1 : 0;
    endfunction

    task automatic drive(input bit v, input int rs, input int rs_t, input int rt, input int rt_t,
                         input int wr, input int tn, input bit mds, input bit mdd,
                         input bit mdu, input bit fl);
        d_valid    = v;
        d_rs_addr  = 5'(rs);
        d_rs_tuse  = 2'(rs_t);
        d_rt_addr  = 5'(rt);
        d_rt_tuse  = 2'(rt_t);
        d_wr_addr  = 5'(wr);
        d_tnew     = 2'(tn);
        d_md_start = mds;
        d_md_div   = mdd;
        d_md_use   = mdu;
        flush      = fl;
    endtask

    task automatic nop();
        drive(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_check();
        chk("stall",    4'(stall),    4'(exp_stall()));
        chk("fwd_rs_d", 4'(fwd_rs_d), 4'(exp_fwd_d(int'(d_rs_addr))));
        chk("fwd_rt_d", 4'(fwd_rt_d), 4'(exp_fwd_d(int'(d_rt_addr))));
        chk("fwd_rs_e", 4'(fwd_rs_e), 4'(exp_fwd_e(0)));
        chk("fwd_rt_e", 4'(fwd_rt_e), 4'(exp_fwd_e(1)));
        chk("fwd_rt_m", 4'(fwd_rt_m), 4'(exp_fwd_m()));
        chk("md_busy",  4'(md_busy),  4'(exp_busy()));
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        bit st;
        ent_t e;
        st = exp_stall();
        @(posedge clk);
        if (flush) q.delete();
        else if (d_valid && !st) begin
            e.wr = int'(d_wr_addr); e.rs = int'(d_rs_addr); e.rt = int'(d_rt_addr);
            e.tnew = int'(d_tnew); e.enter = cyc + 1;
            q.push_back(e);
            if (d_md_start) begin
                md_have = 1;
                md_iss  = cyc;
                md_lat  = d_md_div ? 10 : 5;
            end
        end
        cyc++;
        for (int i = q.size() - 1; i >= 0; i--)
            if (cyc - q[i].enter > 2) q.delete(i);
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    initial begin
        reset = 1'b0;
        nop();
        #2;
        chk("rst_stall",    4'(stall),    4'd0);
        chk("rst_fwd_rs_d", 4'(fwd_rs_d), 4'd0);
        chk("rst_fwd_rt_d", 4'(fwd_rt_d), 4'd0);
        chk("rst_fwd_rs_e", 4'(fwd_rs_e), 4'd0);
        chk("rst_fwd_rt_e", 4'(fwd_rt_e), 4'd0);
        chk("rst_fwd_rt_m", 4'(fwd_rt_m), 4'd0);
        chk("rst_md_busy",  4'(md_busy),  4'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // lw $1 ; addu $4,$1,$5
        drive(1, 2, 1, 0, 3, 1, 2, 0, 0, 0, 0); tick();
        drive(1, 1, 1, 5, 1, 4, 1, 0, 0, 0, 0);
        settle(); chk("lw_use_stall", 4'(stall), 4'd1); advance();
        settle(); chk("lw_use_release", 4'(stall), 4'd0); advance();
        nop();
        settle(); chk("lw_use_fwd_e_w", 4'(fwd_rs_e), 4'd3); advance();
        tick(); tick();

        // addu $2 ; beq $2,$0
        drive(1, 5, 1, 6, 1, 2, 1, 0, 0, 0, 0); tick();
        drive(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); chk("alu_br_stall", 4'(stall), 4'd1); advance();
        settle(); chk("alu_br_release", 4'(stall), 4'd0);
        chk("alu_br_fwd_m", 4'(fwd_rs_d), 4'd2); advance();
        nop(); tick(); tick();

        // jal ; jr $31
        drive(1, 0, 3, 0, 3, 31, 0, 0, 0, 0, 0); tick();
        drive(1, 31, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        settle(); chk("jal_jr_stall", 4'(stall), 4'd0);
        chk("jal_jr_fwd_e", 4'(fwd_rs_d), 4'd1); advance();
        nop(); tick(); tick();

        // write to $0 then read $0
        drive(1, 5, 1, 6, 1, 0, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        settle(); chk("r0_stall", 4'(stall), 4'd0);
        chk("r0_fwd_rs_d", 4'(fwd_rs_d), 4'd0);
        chk("r0_fwd_rt_d", 4'(fwd_rt_d), 4'd0); advance();
        nop(); tick(); tick(); tick();

        // div ; mflo
        drive(1, 5, 1, 6, 1, 0, 0, 1, 1, 1, 0); tick();
        drive(1, 0, 3, 0, 3, 8, 1, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            settle(); chk("div_busy", 4'(md_busy), 4'd1);
            chk("div_mflo_stall", 4'(stall), 4'd1); advance();
        end
        settle(); chk("div_done_busy", 4'(md_busy), 4'd0);
        chk("div_done_stall", 4'(stall), 4'd0); advance();
        nop(); tick(); tick(); tick();

        // lw $3 pending, flush, then reader of $3
        drive(1, 2, 1, 0, 3, 3, 2, 0, 0, 0, 0); tick();
        drive(1, 3, 0, 0, 3, 9, 1, 0, 0, 0, 1); tick();
        drive(1, 3, 0, 0, 3, 9, 1, 0, 0, 0, 0);
        settle(); chk("flush_stall", 4'(stall), 4'd0);
        chk("flush_fwd_rs_d", 4'(fwd_rs_d), 4'd0); advance();
        nop(); tick(); tick(); tick();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit v, fl, mds, mdu;
            v   = ($urandom_range(0, 9) < 8);
            fl  = ($urandom_range(0, 39) == 0);
            mds = ($urandom_range(0, 19) == 0);
            mdu = mds || ($urandom_range(0, 9) == 0);
            drive(v, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2),
                  mds, $urandom_range(0, 1) == 1, mdu, fl);
            tick();
        end

        // async reset in the middle of a divide
        nop(); tick(); tick(); tick();
        drive(1, 5, 1, 6, 1, 0, 0, 1, 1, 1, 0); tick();
        drive(1, 0, 3, 0, 3, 8, 1, 0, 0, 1, 0); tick(); tick();
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy",  4'(md_busy),  4'd0);
        chk("mid_rst_stall", 4'(stall),    4'd0);
        chk("mid_rst_fwd",   4'(fwd_rs_e), 4'd0);
        q.delete();
        md_have = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
